// File: rtl/decoder_3to8_reg.sv
// decoder_3to8_reg: 74x138-style 3-to-8 line decoder with three enables.
// The select code {c,b,a} chooses one of eight outputs. That output is asserted
// while g1=1 and g2a=g2b=0. Output polarity and output registering are set by
// parameters. When registered, a synchronous active-high reset forces the
// outputs to their idle value.
module decoder_3to8_reg #(
    parameter bit ACTIVE_LOW   = 1'b1,  // 1: asserted output is 0, idle outputs are 1
    parameter bit REGISTER_OUT = 1'b1   // 1: Y/en_o registered with 1-cycle latency
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       g1,
    input  logic       g2a,
    input  logic       g2b,
    input  logic       c,
    input  logic       b,
    input  logic       a,
    output logic [7:0] Y,
    output logic       en_o
);

    // Output value when the decoder is disabled or held in reset.
    localparam logic [7:0] IDLE = {8{ACTIVE_LOW}};

    logic [2:0] sel;
    logic       enable;
    logic [7:0] onehot;
    logic [7:0] y_d;

    // Combinational decode. Any inactive enable forces every output idle.
    always_comb begin
        sel    = {c, b, a};
        enable = g1 & ~g2a & ~g2b;
        onehot = '0;
        if (enable) begin
            onehot[sel] = 1'b1;
        end
        y_d = ACTIVE_LOW ? ~onehot : onehot;
    end

    generate
        if (REGISTER_OUT) begin : g_reg
            logic [7:0] y_q;
            logic       en_q;

            // Output register. Reset overrides all inputs. Otherwise the register loads the decoded inputs each cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_q  <= IDLE;
                    en_q <= 1'b0;
                end else begin
                    y_q  <= y_d;
                    en_q <= enable;
                end
            end

            assign Y    = y_q;
            assign en_o = en_q;
        end else begin : g_comb
            // clk and rst have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = ^{clk, rst};

            assign Y    = y_d;
            assign en_o = enable;
        end
    endgenerate

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Testbench for decoder_3to8_reg. It drives three builds with shared inputs:
// registered active-low, registered active-high, and combinational active-low.
// A behavioural model computes the expected outputs from the decode rules.
module tb_decoder_3to8_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic g1 = 1'b0, g2a = 1'b0, g2b = 1'b0;
    logic c = 1'b0, b = 1'b0, a = 1'b0;

    logic [7:0] y_al, y_ah, y_cb;
    logic       en_al, en_ah, en_cb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_3to8_reg #(.ACTIVE_LOW(1'b1), .REGISTER_OUT(1'b1)) dut_al (
        .clk(clk), .rst(rst), .g1(g1), .g2a(g2a), .g2b(g2b),
        .c(c), .b(b), .a(a), .Y(y_al), .en_o(en_al)
    );

    decoder_3to8_reg #(.ACTIVE_LOW(1'b0), .REGISTER_OUT(1'b1)) dut_ah (
        .clk(clk), .rst(rst), .g1(g1), .g2a(g2a), .g2b(g2b),
        .c(c), .b(b), .a(a), .Y(y_ah), .en_o(en_ah)
    );

    decoder_3to8_reg #(.ACTIVE_LOW(1'b1), .REGISTER_OUT(1'b0)) dut_cb (
        .clk(clk), .rst(rst), .g1(g1), .g2a(g2a), .g2b(g2b),
        .c(c), .b(b), .a(a), .Y(y_cb), .en_o(en_cb)
    );

    // Reference: output i is asserted only when the decoder is enabled and i equals sel.
    function automatic logic [7:0] model(input bit mg1, input bit mg2a, input bit mg2b,
                                         input int msel, input bit al);
        logic [7:0] r;
        bit en;
        en = mg1 && !mg2a && !mg2b;
        for (int i = 0; i < 8; i++) begin
            r[i] = (en && (i == msel)) ? !al : al;
        end
        return r;
    endfunction

    function automatic bit model_en(input bit mg1, input bit mg2a, input bit mg2b);
        return mg1 && !mg2a && !mg2b;
    endfunction

    task automatic set_in(input bit vg1, input bit vg2a, input bit vg2b, input int s);
        g1 = vg1;
        g2a = vg2a;
        g2b = vg2b;
        {c, b, a} = 3'(s);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 3);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (y_al !== 8'hFF) begin errors++; $display("FAIL reset_y_al got %h want ff", y_al); end
        checks++;
        if (en_al !== 1'b0) begin errors++; $display("FAIL reset_en_al got %b want 0", en_al); end
        checks++;
        if (y_ah !== 8'h00) begin errors++; $display("FAIL reset_y_ah got %h want 00", y_ah); end
        checks++;
        if (en_ah !== 1'b0) begin errors++; $display("FAIL reset_en_ah got %b want 0", en_ah); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (y_al !== 8'hF7) begin errors++; $display("FAIL reset_release_y got %h want f7", y_al); end
        checks++;
        if (en_al !== 1'b1) begin errors++; $display("FAIL reset_release_en got %b want 1", en_al); end
        checks++;
        if (y_ah !== 8'h08) begin errors++; $display("FAIL reset_release_y_ah got %h want 08", y_ah); end
    endtask

    task automatic test_sweep;
        logic [7:0] tbl [8];
        logic [7:0] one;
        tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        for (int s = 0; s < 8; s++) begin
            set_in(1'b1, 1'b0, 1'b0, s);
            #1;
            checks++;
            if (y_cb !== tbl[s]) begin errors++; $display("FAIL sweep_comb sel=%0d got %h want %h", s, y_cb, tbl[s]); end
            @(posedge clk);
            #1;
            one = 8'h01;
            one = one << s;
            checks++;
            if (y_al !== tbl[s]) begin errors++; $display("FAIL sweep_al sel=%0d got %h want %h", s, y_al, tbl[s]); end
            checks++;
            if (y_ah !== one) begin errors++; $display("FAIL sweep_ah sel=%0d got %h want %h", s, y_ah, one); end
            checks++;
            if (en_al !== 1'b1) begin errors++; $display("FAIL sweep_en sel=%0d got %b want 1", s, en_al); end
        end
    endtask

    task automatic test_disables;
        for (int k = 0; k < 3; k++) begin
            set_in(k != 0, k == 1, k == 2, 5);
            @(posedge clk);
            #1;
            checks++;
            if (y_al !== 8'hFF) begin errors++; $display("FAIL disable%0d_y got %h want ff", k, y_al); end
            checks++;
            if (en_al !== 1'b0) begin errors++; $display("FAIL disable%0d_en got %b want 0", k, en_al); end
            checks++;
            if (y_ah !== 8'h00) begin errors++; $display("FAIL disable%0d_y_ah got %h want 00", k, y_ah); end
            checks++;
            if (y_cb !== 8'hFF) begin errors++; $display("FAIL disable%0d_comb got %h want ff", k, y_cb); end
        end
        set_in(1'b1, 1'b0, 1'b0, 5);
        @(posedge clk);
        #1;
        checks++;
        if (y_al !== 8'hDF) begin errors++; $display("FAIL disable_restore got %h want df", y_al); end
        checks++;
        if (en_al !== 1'b1) begin errors++; $display("FAIL disable_restore_en got %b want 1", en_al); end
    endtask

    task automatic test_toggles;
        int start;
        bit tg1, tg2a, tg2b;
        int s;
        logic [7:0] exp_al, exp_ah;
        start = int'($urandom_range(0, 7));
        for (int cyc = 0; cyc < 64; cyc++) begin
            tg1 = ((cyc / 10) % 2) == 0;
            tg2a = ((cyc / 12) % 2) == 1;
            tg2b = ((cyc / 15) % 2) == 1;
            s = (start + cyc) % 8;
            set_in(tg1, tg2a, tg2b, s);
            exp_al = model(tg1, tg2a, tg2b, s, 1'b1);
            exp_ah = model(tg1, tg2a, tg2b, s, 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (y_al !== exp_al) begin errors++; $display("FAIL toggle_al cyc=%0d got %h want %h", cyc, y_al, exp_al); end
            checks++;
            if (y_ah !== exp_ah) begin errors++; $display("FAIL toggle_ah cyc=%0d got %h want %h", cyc, y_ah, exp_ah); end
            checks++;
            if (en_al !== model_en(tg1, tg2a, tg2b)) begin
                errors++; $display("FAIL toggle_en cyc=%0d got %b want %b", cyc, en_al, model_en(tg1, tg2a, tg2b));
            end
        end
    endtask

    task automatic test_mid_reset;
        set_in(1'b1, 1'b0, 1'b0, 6);
        @(posedge clk);
        #1;
        checks++;
        if (y_al !== 8'hBF) begin errors++; $display("FAIL midrst_pre got %h want bf", y_al); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y_al !== 8'hFF) begin errors++; $display("FAIL midrst_y got %h want ff", y_al); end
        checks++;
        if (en_al !== 1'b0) begin errors++; $display("FAIL midrst_en got %b want 0", en_al); end
        checks++;
        if (y_ah !== 8'h00) begin errors++; $display("FAIL midrst_y_ah got %h want 00", y_ah); end
        checks++;
        if (y_cb !== 8'hBF) begin errors++; $display("FAIL midrst_comb got %h want bf", y_cb); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (y_al !== 8'hBF) begin errors++; $display("FAIL midrst_post got %h want bf", y_al); end
    endtask

    task automatic test_random;
        bit rg1, rg2a, rg2b, rr;
        int s;
        logic [7:0] exp_al, exp_ah, exp_cb;
        bit exp_en;
        for (int n = 0; n < 200; n++) begin
            rg1 = ($urandom_range(0, 3) != 0);
            rg2a = ($urandom_range(0, 3) == 0);
            rg2b = ($urandom_range(0, 3) == 0);
            rr = ($urandom_range(0, 7) == 0);
            s = int'($urandom_range(0, 7));
            set_in(rg1, rg2a, rg2b, s);
            rst = rr;
            exp_cb = model(rg1, rg2a, rg2b, s, 1'b1);
            #1;
            checks++;
            if (y_cb !== exp_cb) begin errors++; $display("FAIL rand_comb n=%0d got %h want %h", n, y_cb, exp_cb); end
            checks++;
            if (en_cb !== model_en(rg1, rg2a, rg2b)) begin
                errors++; $display("FAIL rand_comb_en n=%0d got %b want %b", n, en_cb, model_en(rg1, rg2a, rg2b));
            end
            exp_al = rr ? 8'hFF : exp_cb;
            exp_ah = rr ? 8'h00 : model(rg1, rg2a, rg2b, s, 1'b0);
            exp_en = rr ? 1'b0 : model_en(rg1, rg2a, rg2b);
            @(posedge clk);
            #1;
            checks++;
            if (y_al !== exp_al) begin errors++; $display("FAIL rand_al n=%0d got %h want %h", n, y_al, exp_al); end
            checks++;
            if (y_ah !== exp_ah) begin errors++; $display("FAIL rand_ah n=%0d got %h want %h", n, y_ah, exp_ah); end
            checks++;
            if (en_ah !== exp_en) begin errors++; $display("FAIL rand_en n=%0d got %b want %b", n, en_ah, exp_en); end
        end
        rst = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_sweep();
        test_disables();
        test_toggles();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_3to8_reg.md
Name: decoder_3to8_reg

Overview:
Registered 74x138-style 3-to-8 line decoder with three enable inputs: one active-high (g1) and two active-low (g2a, g2b). The select code {c,b,a} chooses one of eight outputs, which is driven to its asserted level while the decoder is enabled. Used as a chip-select / one-hot strobe generator in the base logic library. Outputs are registered on the system clock and cleared by a synchronous reset.

Parameters:
ACTIVE_LOW, 1, output polarity: 1 = asserted output is 0, idle outputs are 1 (74x138 convention); 0 = one-hot active-high.
REGISTER_OUT, 1, 1 = Y and en_o registered (1-cycle latency); 0 = combinational path, reset has no effect on outputs.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous reset, active-high
g1   input  1  enable, active-high
g2a  input  1  enable, active-low
g2b  input  1  enable, active-low
c    input  1  select bit 2 (MSB)
b    input  1  select bit 1
a    input  1  select bit 0 (LSB)
Y    output 8  decoded outputs; Y[i] corresponds to select code i
en_o output 1  decoder-enabled status (g1 & ~g2a & ~g2b), registered alongside Y

Behaviour:
- sel = {c,b,a}, unsigned 0..7. enable = g1 & ~g2a & ~g2b.
- Decode, ACTIVE_LOW=1: if enable, Y = ~(8'b1 << sel), so exactly one bit is 0. If not enabled, Y = 8'hFF.
- Decode, ACTIVE_LOW=0: if enable, Y = 8'b1 << sel. If not enabled, Y = 8'h00.
- Disable dominates: any one of g1=0, g2a=1 or g2b=1 forces all outputs idle, regardless of sel and of the other enables.
- REGISTER_OUT=1:
  - Y and en_o update on each rising edge of clk from the inputs sampled at that edge.
  - Latency is exactly 1 cycle; there is no handshake and a new code is accepted every cycle.
- Reset (REGISTER_OUT=1):
  - rst=1 at a rising edge sets Y to its idle value (8'hFF when ACTIVE_LOW=1, 8'h00 otherwise) and en_o to 0.
  - Reset overrides all inputs and takes effect even when asserted mid-stream.
  - The first edge after rst is released loads the decoded inputs normally.
- REGISTER_OUT=0: Y and en_o follow the inputs combinationally; clk and rst are unused.
- Sel transitions (including the wrap 7 -> 0) have no sequencing effect; each cycle is decoded independently.
- Invariants while enabled: exactly one output is asserted; the asserted bit index equals sel.
- Invariant while disabled: zero outputs are asserted.
- X/Z inputs do not need defined handling; the bench drives only 0/1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with g1=1, g2a=0, g2b=0, sel=3 -> Y=8'hFF and en_o=0; first edge after release -> Y=8'hF7, en_o=1.
- Full sweep enabled: g1=1, g2a=0, g2b=0, sel 0..7 one per cycle -> Y one cycle later is FE, FD, FB, F7, EF, DF, BF, 7F.
- Each disable individually, at sel=5: g1=0, then g2a=1, then g2b=1 (others enabling) -> Y=8'hFF, en_o=0 for each; restoring enables -> Y=8'hDF.
- Independent toggles: toggle g1, g2a and g2b on different periods (10/12/15 cycles) while sel increments with wrap 7 -> 0 -> Y matches the golden model every cycle, including across the 7 -> 0 wrap.
- Reset mid-operation: at sel=6 enabled (Y=8'hBF), assert rst for 1 cycle -> Y=8'hFF next edge; deassert -> Y=8'hBF the following edge.
- ACTIVE_LOW=0 build: same sweep -> Y = 01, 02, 04 ... 80; disabled or reset -> 8'h00.
